// File: rtl/ubit_pkg.sv
// Shared types and defaults for the unary bitstream decoder.
package ubit_pkg;
  localparam int BITWIDTH_DEF = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} ubit_state_t;
endpackage

// File: rtl/ubit_wincnt.sv
// Window position counter: counts enabled bits, raises tc on the last slot of the window.
module ubit_wincnt #(
  parameter int BITWIDTH = ubit_pkg::BITWIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [BITWIDTH-1:0] cnt;

  // Wraps to zero naturally when the final slot is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + BITWIDTH'(1);
    end
  end

  assign tc = &cnt;
endmodule

// File: rtl/ubit_decoder.sv
// Recovers a binary value from a unary bitstream by counting ones over 2^BITWIDTH enabled bits.
module ubit_decoder
  import ubit_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iBit,
  input  logic                iAck,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH:0]   oValue
);
  ubit_state_t         state_q, state_d;
  logic [BITWIDTH:0]   ones_q;
  logic                win_tc;
  logic                accumulate;
  logic                complete;
  logic [BITWIDTH:0]   ones_next;

  // A start always wins over accumulation or completion in the same cycle.
  assign accumulate = (state_q == ACCUM) && !iStart && iEn;
  assign complete   = accumulate && win_tc;
  assign ones_next  = ones_q + {{BITWIDTH{1'b0}}, iBit};

  ubit_wincnt #(.BITWIDTH(BITWIDTH)) u_wincnt (
    .clk (iClk),
    .rst (iRst),
    .clr (iStart),
    .en  (accumulate),
    .tc  (win_tc)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = ACCUM;
      ACCUM:   if (iStart) state_d = ACCUM;
               else if (complete) state_d = DONE;
      DONE:    if (iStart) state_d = ACCUM;
               else if (iAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ones_q <= '0;
      oValue <= '0;
    end else begin
      if (iStart) begin
        ones_q <= '0;
      end else if (accumulate) begin
        ones_q <= ones_next;
      end
      if (complete) begin
        oValue <= ones_next;
      end
    end
  end

  assign oBusy  = (state_q == ACCUM);
  assign oValid = (state_q == DONE);
endmodule
